instr_decode: RTL
=================

INSTR_DECODE -- requirements
Module: instr_decode

Interface
REQ-001 SHALL have ports clk (in, 1, single clock, rising edge) and rst_n (in, 1, asynchronous active-low reset), listed first.
REQ-002 SHALL have in_valid (in, 1) and in_instr (in, 32): instruction offered by fetch.
REQ-003 SHALL have in_ready (out, 1): decode accepts in_instr this cycle.
REQ-004 SHALL have out_valid (out, 1) and out_ready (in, 1): handshake toward the ALU.
REQ-005 SHALL have out_a (out, 32), out_b (out, 32), out_opcode (out, 7), out_funct3 (out, 3), out_rd (out, 5): ALU operands, control and destination.
REQ-006 SHALL have wb_en (in, 1), wb_rd (in, 5), wb_data (in, 32): ALU result writeback.
REQ-007 SHALL have illegal (out, 1): one-cycle pulse on an unsupported instruction.

Function
REQ-008 SHALL contain a 32x32 register file; x0 SHALL always read 0, and writes to x0 SHALL be ignored.
REQ-009 SHALL accept an instruction when in_valid && in_ready.
REQ-010 in_ready SHALL be (!out_valid || out_ready) && !stall.
REQ-011 LUI (0110111): out_a = {instr[31:12], 12'b0}, out_b = 0.
REQ-012 OP_IMM (0010011) with funct3 000 or 111: out_a = rs1 value (instr[19:15]), out_b = sign-extended instr[31:20].
REQ-013 Any other opcode or funct3 SHALL be consumed and dropped (no out_valid, no scoreboard change), and SHALL pulse illegal the following cycle.
REQ-014 Output SHALL be a single register stage: an accepted legal instruction appears on out_* with out_valid=1 in the next cycle (latency 1).
REQ-015 out_* SHALL hold stable while out_valid && !out_ready.
REQ-016 out_valid SHALL drop after a handshake unless a new instruction is accepted in the same cycle (back-to-back throughput of 1 per cycle).
REQ-017 Scoreboard: 32 busy bits.
  - Accepting a legal instruction with rd != 0 SHALL set busy[rd].
  - wb_en with wb_rd != 0 SHALL clear busy[wb_rd] and write wb_data to the register file.
REQ-018 Simultaneous set and clear on the same index SHALL leave busy set (issue wins).
REQ-019 stall SHALL be 1 when an OP_IMM on in_instr has busy[rs1] set, rs1 != 0, and not (wb_en && wb_rd == rs1).
REQ-020 When wb_en && wb_rd == rs1 in the accept cycle, wb_data SHALL be bypassed into out_a.
REQ-021 LUI SHALL never stall; LUI and illegal instructions SHALL ignore rs1.
REQ-022 Writeback SHALL be accepted every cycle regardless of stall or out_ready.

Reset
REQ-023 While rst_n=0:
  - out_valid=0, illegal=0, out_a/out_b/out_opcode/out_funct3/out_rd=0
  - all busy bits = 0
  - all registers = 0
REQ-024 Reset asserted mid-operation SHALL discard any pending output without a handshake; in_ready SHALL be 1 in the first cycle after release.

Structure
REQ-025 Shared package SHALL hold the opcode constants (LUI, OP_IMM), the funct3 constants (ADDI=000, ANDI=111), and the XLEN=32 and register-count=32 constants; the ALU SHALL use the same package.
REQ-026 The register file SHALL be a separate sub-module, regfile: 1 async read port, 1 sync write port, x0 hardwired to 0.
REQ-027 The scoreboard, hazard logic and output register SHALL live in instr_decode.

Verification
REQ-028 After reset, LUI x1,0x12345 with out_ready=1 -> next cycle out_valid=1, out_a=0x12345000, out_b=0, out_rd=1, busy[1]=1.
REQ-029 ADDI x2,x1,-1 issued while busy[1] set and no writeback -> in_ready=0; then wb_en, wb_rd=1, wb_data=0x12345000 -> accepted that cycle, out_a=0x12345000, out_b=0xFFFFFFFF.
REQ-030 out_ready=0 for 3 cycles with out_valid=1 -> out_* unchanged, in_ready=0; out_ready=1 -> handshake, next instruction accepted the same cycle.
REQ-031 Opcode 0110011 -> illegal pulses 1 cycle, out_valid stays 0, no busy bit set.
REQ-032 ANDI x0,x0,0x7FF -> out_a=0, out_b=0x000007FF, busy unchanged; a later wb to x0 with 0xDEAD -> x0 still reads 0.
REQ-033 rst_n low while out_valid=1 and busy[1] set -> out_valid=0, busy cleared, in_ready=1 after release.

Source files
------------

// File: rtl/instr_decode_pkg.sv
// Shared decode/ALU definitions: datapath widths, supported opcodes and funct3 codes.
package instr_decode_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned NREGS  = 32;
    localparam int unsigned RIDX_W = $clog2(NREGS);

    typedef enum logic [6:0] {
        OPC_OP_IMM = 7'b0010011,
        OPC_LUI    = 7'b0110111
    } opcode_e;

    typedef enum logic [2:0] {
        F3_ADDI = 3'b000,
        F3_ANDI = 3'b111
    } funct3_e;

    function automatic logic [XLEN-1:0] sext12(input logic [11:0] imm);
        return {{(XLEN-12){imm[11]}}, imm};
    endfunction

endpackage

// File: rtl/instr_decode_regfile.sv
// Integer register file: one combinational read port, one clocked write port, x0 reads as zero.
module regfile
    import instr_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [RIDX_W-1:0] raddr_i,
    output logic [XLEN-1:0]   rdata_o,
    input  logic              we_i,
    input  logic [RIDX_W-1:0] waddr_i,
    input  logic [XLEN-1:0]   wdata_i
);

    logic [XLEN-1:0] regs_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = (raddr_i == '0) ? '0 : regs_q[raddr_i];

endmodule

// File: rtl/instr_decode.sv
// Decode stage: LUI / ADDI / ANDI operand fetch with busy-bit scoreboard,
// writeback bypass and a single registered output toward the ALU.
module instr_decode
    import instr_decode_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_instr,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_a,
    output logic [XLEN-1:0]   out_b,
    output logic [6:0]        out_opcode,
    output logic [2:0]        out_funct3,
    output logic [RIDX_W-1:0] out_rd,
    input  logic              wb_en,
    input  logic [RIDX_W-1:0] wb_rd,
    input  logic [XLEN-1:0]   wb_data,
    output logic              illegal
);

    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [RIDX_W-1:0] rd;
    logic [RIDX_W-1:0] rs1;
    logic              is_lui;
    logic              is_opimm;
    logic              legal;
    logic              bypass;
    logic              stall;
    logic              accept;
    logic              issue;
    logic [XLEN-1:0]   rf_rdata;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   a_d;
    logic [XLEN-1:0]   b_d;

    logic [NREGS-1:0]  busy_q, busy_d;
    logic              out_valid_q;
    logic              illegal_q;
    logic [XLEN-1:0]   out_a_q;
    logic [XLEN-1:0]   out_b_q;
    logic [6:0]        out_opcode_q;
    logic [2:0]        out_funct3_q;
    logic [RIDX_W-1:0] out_rd_q;

    assign opc      = in_instr[6:0];
    assign rd       = in_instr[11:7];
    assign f3       = in_instr[14:12];
    assign rs1      = in_instr[19:15];

    assign is_lui   = (opc == OPC_LUI);
    assign is_opimm = (opc == OPC_OP_IMM) && ((f3 == F3_ADDI) || (f3 == F3_ANDI));
    assign legal    = is_lui || is_opimm;

    // Only a legal OP_IMM reads rs1; a same-cycle writeback resolves the hazard.
    assign bypass   = wb_en && (wb_rd == rs1) && (rs1 != '0);
    assign stall    = is_opimm && busy_q[rs1] && (rs1 != '0) && !bypass;
    assign in_ready = (!out_valid_q || out_ready) && !stall;
    assign accept   = in_valid && in_ready;
    assign issue    = accept && legal;

    regfile u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .raddr_i (rs1),
        .rdata_o (rf_rdata),
        .we_i    (wb_en),
        .waddr_i (wb_rd),
        .wdata_i (wb_data)
    );

    assign rs1_val = bypass ? wb_data : rf_rdata;
    assign a_d     = is_lui ? {in_instr[31:12], 12'b0} : rs1_val;
    assign b_d     = is_lui ? '0 : sext12(in_instr[31:20]);

    // Clear is applied before set so an issue to the same index wins.
    always_comb begin
        busy_d = busy_q;
        if (wb_en && (wb_rd != '0)) begin
            busy_d[wb_rd] = 1'b0;
        end
        if (issue && (rd != '0)) begin
            busy_d[rd] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q       <= '0;
            out_valid_q  <= 1'b0;
            illegal_q    <= 1'b0;
            out_a_q      <= '0;
            out_b_q      <= '0;
            out_opcode_q <= '0;
            out_funct3_q <= '0;
            out_rd_q     <= '0;
        end else begin
            busy_q    <= busy_d;
            illegal_q <= accept && !legal;
            if (issue) begin
                out_valid_q  <= 1'b1;
                out_a_q      <= a_d;
                out_b_q      <= b_d;
                out_opcode_q <= opc;
                out_funct3_q <= f3;
                out_rd_q     <= rd;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign illegal    = illegal_q;
    assign out_a      = out_a_q;
    assign out_b      = out_b_q;
    assign out_opcode = out_opcode_q;
    assign out_funct3 = out_funct3_q;
    assign out_rd     = out_rd_q;

endmodule
